// File: rtl/alu_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader_if
// Description : Switch/button inputs and active-low ALU operand outputs
//               of the operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_loader_if;
    logic [3:0] sw_n;
    logic       btn_n;
    logic [3:0] a_n;
    logic [3:0] b_n;
    logic [2:0] op_n;
    logic [3:0] stage_n;
    logic       valid;

    // Board side: drives the switches and button, observes captured values
    modport master (
        output sw_n,
        output btn_n,
        input  a_n,
        input  b_n,
        input  op_n,
        input  stage_n,
        input  valid
    );

    // Loader side
    modport slave (
        input  sw_n,
        input  btn_n,
        output a_n,
        output b_n,
        output op_n,
        output stage_n,
        output valid
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader
// Description : Captures ALU operand A, operand B and opcode from active-low
//               switches, one field per debounced button press.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    alu_operand_loader_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_A   = 2'd0,
        ST_B   = 2'd1,
        ST_OP  = 2'd2,
        ST_RUN = 2'd3
    } state_t;

    logic             r_btn_s1;
    logic             r_btn_s2;
    logic [3:0]       r_sw_s1;
    logic [3:0]       r_sw_s2;
    logic             r_btn_db;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    state_t           r_state;
    logic [3:0]       r_a_n;
    logic [3:0]       r_b_n;
    logic [2:0]       r_op_n;
    logic [3:0]       r_stage_n;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1 <= 1'b1;
            r_btn_s2 <= 1'b1;
            r_sw_s1  <= 4'hF;
            r_sw_s2  <= 4'hF;
        end else begin
            r_btn_s1 <= bus.btn_n;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= bus.sw_n;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Debounced state is active-low like the pin: 1 = released.
    // The press pulse is registered so it lands one edge after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_db <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_btn_s2 == r_btn_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_btn_db <= r_btn_s2;
                r_cnt    <= '0;
                r_press  <= ~r_btn_s2;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_A;
            r_a_n     <= 4'hF;
            r_b_n     <= 4'hF;
            r_op_n    <= 3'h7;
            r_stage_n <= 4'b1110;
            r_valid   <= 1'b0;
        end else if (r_press) begin
            case (r_state)
                ST_A: begin
                    r_a_n     <= r_sw_s2;
                    r_state   <= ST_B;
                    r_stage_n <= 4'b1101;
                    r_valid   <= 1'b0;
                end
                ST_B: begin
                    r_b_n     <= r_sw_s2;
                    r_state   <= ST_OP;
                    r_stage_n <= 4'b1011;
                    r_valid   <= 1'b0;
                end
                ST_OP: begin
                    r_op_n    <= r_sw_s2[2:0];
                    r_state   <= ST_RUN;
                    r_stage_n <= 4'b0111;
                    r_valid   <= 1'b1;
                end
                default: begin
                    r_state   <= ST_A;
                    r_stage_n <= 4'b1110;
                    r_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_n     = r_a_n;
    assign bus.b_n     = r_b_n;
    assign bus.op_n    = r_op_n;
    assign bus.stage_n = r_stage_n;
    assign bus.valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_loader
// Description : Directed self-checking bench for alu_operand_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    alu_operand_loader_if bus ();

    alu_operand_loader #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pins seen two edges late; a level is accepted after DB
    // consecutive differing samples; an accepted press steps the loader
    // on the following edge.
    int         m_step;
    int         m_run;
    logic       m_db;
    logic       m_pend;
    logic       m_fire;
    logic       m_ok = 1'b0;
    logic [3:0] m_a, m_b;
    logic [2:0] m_op;
    logic       h_btn [2];
    logic [3:0] h_sw  [2];

    always @(posedge clk) begin
        if (rst) begin
            m_step = 0; m_run = 0; m_db = 1'b1; m_pend = 1'b0;
            m_a = 4'hF; m_b = 4'hF; m_op = 3'h7;
            h_btn[0] = 1'b1; h_btn[1] = 1'b1;
            h_sw[0] = 4'hF;  h_sw[1] = 4'hF;
            m_ok = 1'b1;
        end else begin
            m_fire = m_pend;
            m_pend = 1'b0;
            if (h_btn[1] != m_db) begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_db   = h_btn[1];
                    m_run  = 0;
                    m_pend = (h_btn[1] == 1'b0);
                end
            end else begin
                m_run = 0;
            end
            if (m_fire) begin
                if (m_step == 0) m_a = h_sw[1];
                else if (m_step == 1) m_b = h_sw[1];
                else if (m_step == 2) m_op = h_sw[1][2:0];
                m_step = (m_step + 1) % 4;
            end
            h_btn[1] = h_btn[0]; h_btn[0] = bus.btn_n;
            h_sw[1]  = h_sw[0];  h_sw[0]  = bus.sw_n;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e_stage;
        if (m_ok) begin
            e_stage = 4'b1111;
            e_stage[m_step] = 1'b0;
            chk("model_a_n",     32'(bus.a_n),     32'(m_a));
            chk("model_b_n",     32'(bus.b_n),     32'(m_b));
            chk("model_op_n",    32'(bus.op_n),    32'(m_op));
            chk("model_stage_n", 32'(bus.stage_n), 32'(e_stage));
            chk("model_valid",   32'(bus.valid),   32'(m_step == 3));
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] sw);
        bus.sw_n  = sw;
        bus.btn_n = 1'b0;
        clks(10);
        bus.btn_n = 1'b1;
        clks(10);
    endtask

    initial begin
        bus.sw_n  = 4'hF;
        bus.btn_n = 1'b1;
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        chk("rst_a_n",     32'(bus.a_n),     32'hF);
        chk("rst_b_n",     32'(bus.b_n),     32'hF);
        chk("rst_op_n",    32'(bus.op_n),    32'h7);
        chk("rst_stage_n", 32'(bus.stage_n), 32'b1110);
        chk("rst_valid",   32'(bus.valid),   32'd0);
        clks(2);

        // Full sequence: A=5, B=3, op=ADD
        press(4'hA);
        press(4'hC);
        press(4'hF);
        chk("seq_a_n",     32'(bus.a_n),     32'hA);
        chk("seq_b_n",     32'(bus.b_n),     32'hC);
        chk("seq_op_n",    32'(bus.op_n),    32'h7);
        chk("seq_stage_n", 32'(bus.stage_n), 32'b0111);
        chk("seq_valid",   32'(bus.valid),   32'd1);
        chk("seq_alu_sum", 32'((~bus.a_n + ~bus.b_n) & 4'hF), 32'd8);

        // Wrap from RUN back to A, fields held
        press(4'h0);
        chk("wrap_stage_n", 32'(bus.stage_n), 32'b1110);
        chk("wrap_valid",   32'(bus.valid),   32'd0);
        chk("wrap_a_n",     32'(bus.a_n),     32'hA);
        chk("wrap_op_n",    32'(bus.op_n),    32'h7);

        // Bounce then settle: exactly one press, overwrites A only
        bus.sw_n = 4'h6;
        for (int i = 0; i < 5; i++) begin
            bus.btn_n = 1'b0; clks(2);
            bus.btn_n = 1'b1; clks(2);
        end
        chk("bounce_no_step", 32'(bus.stage_n), 32'b1110);
        bus.btn_n = 1'b0; clks(10);
        bus.btn_n = 1'b1; clks(10);
        chk("bounce_stage_n", 32'(bus.stage_n), 32'b1101);
        chk("bounce_a_n",     32'(bus.a_n),     32'h6);
        chk("bounce_b_n",     32'(bus.b_n),     32'hC);

        // Long hold with switch change after the press
        bus.sw_n  = 4'h9;
        bus.btn_n = 1'b0;
        clks(30);
        bus.sw_n = 4'h2;
        clks(70);
        bus.btn_n = 1'b1;
        clks(10);
        chk("hold_stage_n", 32'(bus.stage_n), 32'b1011);
        chk("hold_b_n",     32'(bus.b_n),     32'h9);

        // Reset with counter at 2 while in OP; button stays held
        bus.sw_n  = 4'h3;
        bus.btn_n = 1'b0;
        clks(4);
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        chk("mrst_a_n",     32'(bus.a_n),     32'hF);
        chk("mrst_b_n",     32'(bus.b_n),     32'hF);
        chk("mrst_stage_n", 32'(bus.stage_n), 32'b1110);
        clks(3);
        chk("mrst_no_early", 32'(bus.stage_n), 32'b1110);
        clks(10);
        chk("mrst_stage_after", 32'(bus.stage_n), 32'b1101);
        chk("mrst_a_after",     32'(bus.a_n),     32'h3);
        bus.btn_n = 1'b1;
        clks(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
